// File: rtl/multicycle_datapath_v2.sv
// Multicycle MIPS datapath (gen 2): PC/IR/MDR/A/B/ALUOut/EPC, register file,
// ALU and source muxes with a stalling memory port and precise interrupts.
module multicycle_datapath_v2 #(
    parameter logic [31:0] RESET_PC   = 32'd128,
    parameter logic [31:0] INT_VECTOR = 32'd4088,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic [2:0]            aluControl,
    input  logic                  aluSrcA,
    input  logic [1:0]            aluSrcB,
    input  logic [1:0]            pcSource,
    input  logic [1:0]            regDst,
    input  logic [1:0]            memToReg,
    input  logic                  regWrite,
    input  logic                  isBranch,
    input  logic                  pcWrite,
    input  logic                  iorD,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  irWrite,
    input  logic                  intReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [31:0]           memWdata,
    input  logic [31:0]           memRdata,
    output logic                  memWe,
    output logic                  memReq,
    input  logic                  memReady,
    output logic [5:0]            op,
    output logic [5:0]            funct,
    output logic                  zero,
    output logic                  stall,
    output logic                  intTaken
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_XOR = 3'b101,
        ALU_NOR = 3'b110,
        ALU_LUI = 3'b111
    } alu_op_e;

    logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d, epc_q, epc_d;
    logic              ie_q, ie_d, pend_q, pend_d, int_taken_q, int_taken_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic [REG_AW-1:0] rs, rt, rd, wreg;
    logic [DATA_W-1:0] rd1, rd2, wdata, sign_imm, src_a, src_b, alu_result;
    logic [DATA_W-1:0] pc_tgt, addr_full;
    logic              pc_en, take_int, rf_we;
    alu_op_e           alu_op;

    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign sign_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign alu_op   = alu_op_e'(aluControl);

    // Memory handshake and status outputs
    assign memReq    = memRead | memWrite;
    assign stall     = memReq & ~memReady;
    assign memWe     = memWrite & ~stall;
    assign addr_full = iorD ? aluout_q : pc_q;
    assign memAddr   = addr_full[ADDR_WIDTH-1:0];
    assign memWdata  = b_q;
    assign op        = ir_q[31:26];
    assign funct     = ir_q[5:0];
    assign intTaken  = int_taken_q;
    assign zero      = (alu_result == '0);

    // Register file read ports; $0 is hard-wired to zero
    assign rd1 = (rs == '0) ? '0 : rf_q[rs];
    assign rd2 = (rt == '0) ? '0 : rf_q[rt];

    // ALU operand muxes and operation
    always_comb begin
        src_a = aluSrcA ? a_q : pc_q;
        unique case (aluSrcB)
            2'b00:   src_b = b_q;
            2'b01:   src_b = 32'd4;
            2'b10:   src_b = sign_imm;
            default: src_b = {sign_imm[29:0], 2'b00};
        endcase
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_SLT: alu_result = DATA_W'($signed(src_a) < $signed(src_b));
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_NOR: alu_result = ~(src_a | src_b);
            ALU_LUI: alu_result = {src_b[15:0], 16'h0000};
            default: alu_result = '0;
        endcase
    end

    // Write-back destination/data and next-PC source muxes
    always_comb begin
        unique case (regDst)
            2'b00:   wreg = rt;
            2'b01:   wreg = rd;
            2'b10:   wreg = REG_AW'(31);
            default: wreg = rs;
        endcase
        unique case (memToReg)
            2'b00:   wdata = aluout_q;
            2'b01:   wdata = mdr_q;
            2'b10:   wdata = pc_q;
            default: wdata = epc_q;
        endcase
        unique case (pcSource)
            2'b00:   pc_tgt = alu_result;
            2'b01:   pc_tgt = aluout_q;
            2'b10:   pc_tgt = {pc_q[31:28], ir_q[25:0], 2'b00};
            default: pc_tgt = epc_q;
        endcase
    end

    assign pc_en    = (isBranch & zero) | pcWrite;
    assign take_int = irWrite & ~stall & pend_q & ie_q;
    assign rf_we    = regWrite & ~stall & (wreg != '0);

    // Next-state for architectural registers; a stall freezes everything
    always_comb begin
        pc_d        = pc_q;
        ir_d        = ir_q;
        mdr_d       = mdr_q;
        a_d         = a_q;
        b_d         = b_q;
        aluout_d    = aluout_q;
        epc_d       = epc_q;
        ie_d        = ie_q;
        pend_d      = pend_q;
        int_taken_d = 1'b0;
        if (!stall) begin
            a_d      = rd1;
            b_d      = rd2;
            aluout_d = alu_result;
            if (memRead) mdr_d = memRdata;
            if (take_int) begin
                // Fetched instruction is dropped: IR untouched, PC redirected
                epc_d       = pc_q;
                pc_d        = INT_VECTOR;
                ie_d        = 1'b0;
                pend_d      = 1'b0;
                int_taken_d = 1'b1;
            end else begin
                if (irWrite) ir_d = memRdata;
                if (pc_en) begin
                    pc_d = pc_tgt;
                    if (pcSource == 2'b11) ie_d = 1'b1;
                end
                if (intReq) pend_d = 1'b1;
            end
        end
    end

    // Datapath state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            mdr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            aluout_q    <= '0;
            epc_q       <= '0;
            ie_q        <= 1'b1;
            pend_q      <= 1'b0;
            int_taken_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            aluout_q    <= aluout_d;
            epc_q       <= epc_d;
            ie_q        <= ie_d;
            pend_q      <= pend_d;
            int_taken_q <= int_taken_d;
        end
    end

    // Register file write port
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[wreg] <= wdata;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath_v2.sv
// Directed bench for multicycle_datapath_v2: ALU vector table plus
// hand-written reset, fetch/stall, branch, register and interrupt sequences.
module tb_multicycle_datapath_v2;

    logic        clk;
    logic        resetN;
    logic [2:0]  aluControl;
    logic        aluSrcA;
    logic [1:0]  aluSrcB, pcSource, regDst, memToReg;
    logic        regWrite, isBranch, pcWrite, iorD, memRead, memWrite, irWrite, intReq;
    logic [31:0] memAddr, memWdata, memRdata;
    logic        memWe, memReq, memReady;
    logic [5:0]  op, funct;
    logic        zero, stall, intTaken;

    int total;
    int bad;

    multicycle_datapath_v2 dut (
        .clk(clk), .resetN(resetN), .aluControl(aluControl), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .pcSource(pcSource), .regDst(regDst), .memToReg(memToReg),
        .regWrite(regWrite), .isBranch(isBranch), .pcWrite(pcWrite), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .intReq(intReq),
        .memAddr(memAddr), .memWdata(memWdata), .memRdata(memRdata), .memWe(memWe),
        .memReq(memReq), .memReady(memReady), .op(op), .funct(funct), .zero(zero),
        .stall(stall), .intTaken(intTaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] alu;
        logic       srcA;
        logic [1:0] srcB;
        logic [1:0] pcSrc;
        logic [1:0] rDst;
        logic [1:0] m2r;
        logic       rWr;
        logic       br;
        logic       pcWr;
        logic       iord;
        logic       mRd;
        logic       mWr;
        logic       irWr;
    } ctrl_t;

    typedef struct {
        string       name;
        logic [2:0]  alu;
        logic        srcA;
        logic [1:0]  srcB;
        logic [31:0] exp;
    } alu_vec_t;

    localparam ctrl_t IDLE = '0;

    task automatic apply(input ctrl_t c, input logic [31:0] rdata, input logic ready, input logic irq);
        aluControl = c.alu;   aluSrcA  = c.srcA;  aluSrcB  = c.srcB;  pcSource = c.pcSrc;
        regDst     = c.rDst;  memToReg = c.m2r;   regWrite = c.rWr;   isBranch = c.br;
        pcWrite    = c.pcWr;  iorD     = c.iord;  memRead  = c.mRd;   memWrite = c.mWr;
        irWrite    = c.irWr;  memRdata = rdata;   memReady = ready;   intReq   = irq;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ctrl_t fetch_c();
        ctrl_t c;
        c = IDLE;
        c.srcB = 2'b01; c.pcWr = 1'b1; c.mRd = 1'b1; c.irWr = 1'b1;
        return c;
    endfunction

    task automatic do_reset();
        ctrl_t c;
        c = IDLE;
        c.srcB = 2'b01; c.pcWr = 1'b1;
        resetN = 1'b0;
        apply(c, 32'h0, 1'b1, 1'b1);
        tick();
        chk("rst_inttaken_during", 32'(intTaken), 32'h0);
        tick();
        resetN = 1'b1;
        apply(IDLE, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic do_fetch(input logic [31:0] instr);
        apply(fetch_c(), instr, 1'b1, 1'b0);
        tick();
    endtask

    // Load MDR with v, then write it to the register chosen by dst
    task automatic write_reg(input logic [31:0] v, input logic [1:0] dst);
        ctrl_t c;
        c = IDLE; c.mRd = 1'b1;
        apply(c, v, 1'b1, 1'b0);
        tick();
        c = IDLE; c.rWr = 1'b1; c.rDst = dst; c.m2r = 2'b01;
        apply(c, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    alu_vec_t vecs[13];

    initial begin
        ctrl_t c;
        total = 0;
        bad   = 0;

        // PC = 0x84, IR = 0x34008001 (rs=rt=0, signImm=0xFFFF8001), A = B = 0
        vecs[0]  = '{"add_imm",   3'b000, 1'b0, 2'b10, 32'hFFFF8085};
        vecs[1]  = '{"sub_imm",   3'b001, 1'b0, 2'b10, 32'h00008083};
        vecs[2]  = '{"and_imm",   3'b010, 1'b0, 2'b10, 32'h00000000};
        vecs[3]  = '{"or_imm",    3'b011, 1'b0, 2'b10, 32'hFFFF8085};
        vecs[4]  = '{"slt_neg",   3'b100, 1'b1, 2'b10, 32'h00000000};
        vecs[5]  = '{"slt_pos",   3'b100, 1'b1, 2'b01, 32'h00000001};
        vecs[6]  = '{"xor_4",     3'b101, 1'b0, 2'b01, 32'h00000080};
        vecs[7]  = '{"nor_imm",   3'b110, 1'b0, 2'b10, 32'h00007F7A};
        vecs[8]  = '{"lui_imm",   3'b111, 1'b0, 2'b10, 32'h80010000};
        vecs[9]  = '{"add_imm_sh",3'b000, 1'b0, 2'b11, 32'hFFFE0088};
        vecs[10] = '{"add_4",     3'b000, 1'b0, 2'b01, 32'h00000088};
        vecs[11] = '{"sub_b",     3'b001, 1'b0, 2'b00, 32'h00000084};
        vecs[12] = '{"sub_a_4",   3'b001, 1'b1, 2'b01, 32'hFFFFFFFC};

        // Reset
        resetN = 1'b0;
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        do_reset();
        chk("rst_pc",       memAddr,           32'd128);
        chk("rst_op",       32'(op),           32'h0);
        chk("rst_funct",    32'(funct),        32'h0);
        chk("rst_inttaken", 32'(intTaken),     32'h0);
        chk("rst_memwe",    32'(memWe),        32'h0);
        chk("rst_wdata",    memWdata,          32'h0);

        // Write handshake, combinational only
        c = IDLE; c.mWr = 1'b1;
        apply(c, 32'h0, 1'b0, 1'b0);
        chk("wr_wait_stall", 32'(stall),  32'h1);
        chk("wr_wait_req",   32'(memReq), 32'h1);
        chk("wr_wait_we",    32'(memWe),  32'h0);
        apply(c, 32'h0, 1'b1, 1'b0);
        chk("wr_ready_stall", 32'(stall), 32'h0);
        chk("wr_ready_we",    32'(memWe), 32'h1);

        // Zero-wait fetch
        apply(fetch_c(), 32'h8C820004, 1'b1, 1'b0);
        chk("f0_stall", 32'(stall), 32'h0);
        chk("f0_addr",  memAddr,    32'd128);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("f0_op",    32'(op),    32'h23);
        chk("f0_funct", 32'(funct), 32'h04);
        chk("f0_pc",    memAddr,    32'd132);

        // Three-wait fetch
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(fetch_c(), 32'hFFFFFFFF, 1'b0, 1'b0);
            chk("f3_stall", 32'(stall), 32'h1);
            chk("f3_hold_pc", memAddr, 32'd128);
            tick();
            chk("f3_hold_ir", 32'(op), 32'h0);
        end
        apply(fetch_c(), 32'h8C820004, 1'b1, 1'b0);
        chk("f3_ready_stall", 32'(stall), 32'h0);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("f3_op", 32'(op), 32'h23);
        chk("f3_pc", memAddr, 32'd132);

        // ALU table
        do_reset();
        do_fetch(32'h34008001);
        for (int i = 0; i < 13; i++) begin
            c = IDLE; c.alu = vecs[i].alu; c.srcA = vecs[i].srcA; c.srcB = vecs[i].srcB;
            apply(c, 32'h0, 1'b1, 1'b0);
            chk({vecs[i].name, "_zero"}, 32'(zero), (vecs[i].exp == 32'h0) ? 32'h1 : 32'h0);
            tick();
            c = IDLE; c.iord = 1'b1;
            apply(c, 32'h0, 1'b1, 1'b0);
            chk(vecs[i].name, memAddr, vecs[i].exp);
        end

        // Branch: beq $1,$2,+17 at PC 132 -> target 200
        do_reset();
        do_fetch(32'h10220011);
        write_reg(32'd5, 2'b11);
        write_reg(32'd5, 2'b00);
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        tick();
        chk("br_b5", memWdata, 32'd5);
        c = IDLE; c.srcB = 2'b11;
        apply(c, 32'h0, 1'b1, 1'b0);
        tick();
        c = IDLE; c.srcA = 1'b1; c.alu = 3'b001; c.br = 1'b1; c.pcSrc = 2'b01;
        apply(c, 32'h0, 1'b1, 1'b0);
        chk("br_taken_zero", 32'(zero), 32'h1);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("br_taken_pc", memAddr, 32'd200);
        write_reg(32'd6, 2'b00);
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        tick();
        chk("br_b6", memWdata, 32'd6);
        c = IDLE; c.srcB = 2'b11;
        apply(c, 32'h0, 1'b1, 1'b0);
        tick();
        c = IDLE; c.srcA = 1'b1; c.alu = 3'b001; c.br = 1'b1; c.pcSrc = 2'b01;
        apply(c, 32'h0, 1'b1, 1'b0);
        chk("br_not_zero", 32'(zero), 32'h0);
        tick();
        c = IDLE; c.iord = 1'b1;
        apply(c, 32'h0, 1'b1, 1'b0);
        chk("br_aluout", memAddr, 32'hFFFFFFFF);
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("br_not_pc", memAddr, 32'd200);

        // Register file: $0 stays zero, jal-style write of PC into $31
        do_reset();
        write_reg(32'hDEADBEEF, 2'b00);
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        chk("r0_zero", memWdata, 32'h0);
        do_fetch(32'h001F0000);
        c = IDLE; c.rWr = 1'b1; c.rDst = 2'b10; c.m2r = 2'b10;
        apply(c, 32'h0, 1'b1, 1'b0);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        tick();
        chk("r31_link", memWdata, 32'd132);

        // Interrupt entry, masked second request, eret, deferred entry
        do_reset();
        do_fetch(32'h08000040);
        c = IDLE; c.pcWr = 1'b1; c.pcSrc = 2'b10;
        apply(c, 32'h0, 1'b1, 1'b1);
        tick();
        apply(fetch_c(), 32'h12345678, 1'b0, 1'b0);
        chk("irq_stall", 32'(stall), 32'h1);
        tick();
        chk("irq_no_take_stall", 32'(intTaken), 32'h0);
        apply(fetch_c(), 32'h12345678, 1'b1, 1'b0);
        chk("irq_fetch_pc", memAddr, 32'h100);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b1);
        chk("irq_taken",  32'(intTaken), 32'h1);
        chk("irq_vector", memAddr,       32'd4088);
        chk("irq_ir_kept", 32'(op),      32'h02);
        tick();
        chk("irq_pulse_end", 32'(intTaken), 32'h0);
        apply(fetch_c(), 32'h42000018, 1'b1, 1'b0);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("irq_masked", 32'(intTaken), 32'h0);
        chk("irq_h_op",   32'(op),       32'h10);
        chk("irq_h_fn",   32'(funct),    32'h18);
        chk("irq_h_pc",   memAddr,       32'd4092);
        c = IDLE; c.pcWr = 1'b1; c.pcSrc = 2'b11;
        apply(c, 32'h0, 1'b1, 1'b0);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("eret_pc", memAddr, 32'h100);
        apply(fetch_c(), 32'h8C820004, 1'b1, 1'b1);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("irq2_taken",  32'(intTaken), 32'h1);
        chk("irq2_vector", memAddr,       32'd4088);
        chk("irq2_ir",     32'(op),       32'h10);
        tick();
        c = IDLE; c.pcWr = 1'b1; c.pcSrc = 2'b11;
        apply(c, 32'h0, 1'b1, 1'b0);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("eret2_pc", memAddr, 32'h100);
        apply(fetch_c(), 32'h8C820004, 1'b1, 1'b0);
        tick();
        apply(IDLE, 32'h0, 1'b1, 1'b0);
        chk("irq3_none", 32'(intTaken), 32'h0);
        chk("irq3_op",   32'(op),       32'h23);
        chk("irq3_pc",   memAddr,       32'h104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath_v2.md
# multicycle_datapath_v2

Parametrised second-generation multicycle MIPS datapath: PC, IR, MDR, A/B, ALUOut, 32×32 register file, ALU and all source muxes, driven cycle-by-cycle by the external multicycle controller. Compared with the first generation, it adds:
- a synchronous reset;
- an external memory port with a ready/stall handshake;
- a precise interrupt mechanism with an EPC register, an interrupt-enable flag and return-from-interrupt;
- a wider ALU opcode and a hard-wired `$0`.

It sits between the controller and the unified instruction/data memory.

## Interface
Parameters:
- `RESET_PC`, 128: PC value loaded on reset.
- `INT_VECTOR`, 4088: handler address loaded into PC when an interrupt is taken.
- `ADDR_WIDTH`, 32: width of `memAddr`, taken from the low bits of the selected 32-bit address.

Ports:
- `clk` in 1: the single clock; all state updates on the rising edge.
- `resetN` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `aluControl` in 3: ALU operation select; see Operation.
- `aluSrcA` in 1: 0 = PC, 1 = A.
- `aluSrcB` in 2: 00 = B, 01 = 4, 10 = signImm, 11 = signImm<<2.
- `pcSource` in 2: 00 = aluResult, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 2'b00}, 11 = EPC (eret).
- `regDst` in 2: 00 = rt, 01 = rd, 10 = 31, 11 = rs.
- `memToReg` in 2: 00 = ALUOut, 01 = MDR, 10 = PC, 11 = EPC.
- `regWrite`, `isBranch`, `pcWrite`, `iorD`, `memRead`, `memWrite`, `irWrite` in 1 each: controller strobes. `iorD`: 0 = PC, 1 = ALUOut.
- `intReq` in 1: level-sensitive external interrupt request.
- `memAddr` out `ADDR_WIDTH`: memory address.
- `memWdata` out 32: always equals the B register.
- `memRdata` in 32: memory read data.
- `memWe` out 1: memory write enable.
- `memReq` out 1: memory access request.
- `memReady` in 1: memory completes the access this cycle.
- `op` out 6: IR[31:26].
- `funct` out 6: IR[5:0].
- `zero` out 1: aluResult == 0.
- `stall` out 1: memory access pending; the controller must hold its state.
- `intTaken` out 1: one-cycle pulse marking interrupt entry.

## Operation
- **ALU (`aluControl`)**:
  - 000 add, 001 sub, 010 and, 011 or, 100 slt (signed, result 0/1), 101 xor, 110 nor, 111 lui (srcB<<16).
  - All arithmetic is 32-bit modulo, with no overflow trap.
- **Memory handshake**:
  - `memReq` = `memRead` | `memWrite`; `memWe` = `memWrite` & ~`stall`.
  - `stall` = `memReq` & ~`memReady`.
  - While `stall`=1, no architectural register changes: PC, IR, MDR, A, B, ALUOut, EPC, regfile, IE and pending are all held.
- **Load enables** (all qualified by ~`stall`):
  - IR loads `memRdata` when `irWrite`.
  - MDR loads `memRdata` when `memRead`.
  - A/B load the regfile rs/rt reads every non-stalled cycle; ALUOut loads aluResult every non-stalled cycle.
  - PC enable = (`isBranch` & `zero`) | `pcWrite`.
- **Register file**: the write is suppressed when the destination is 0. Reads of `$0` return 0. Reads are combinational and return the old value on a same-cycle write to the same register.
- **Interrupts**:
  - The pending flag sets on any cycle with `intReq`=1 and holds until the interrupt is taken.
  - An interrupt is taken at a fetch cycle, defined as `irWrite`=1 & ~`stall` & pending & IE.
  - On the taken edge:
    - EPC <= current PC (the fetched instruction is not executed).
    - PC <= `INT_VECTOR`.
    - IR is NOT written.
    - IE <= 0, pending <= 0.
    - `intTaken`=1 for the following cycle.
  - The controller must return to fetch when it sees `intTaken`.
- **eret**: a PC update with `pcSource`=11 loads PC from EPC and sets IE <= 1.
- **Simultaneous events**:
  - `resetN`=0 overrides everything.
  - Interrupt entry overrides the PC value requested by the controller in that cycle.
  - An `intReq` arriving in the entry cycle re-sets pending only if it is still high after entry.

## Timing
- Reset values:
  - PC = `RESET_PC`.
  - IR, MDR, A, B, ALUOut, EPC and all 32 registers = 0.
  - IE = 1, pending = 0, `intTaken` = 0.
  - Consequently `op`=0, `funct`=0 and `memWe`=0 after reset.
- Combinational outputs: `memAddr`, `memReq`, `stall`, `zero`, `op` and `funct` are combinational from the current state and the current controller inputs.
- Zero-wait memory: `memReady`=1 in the request cycle. The data is captured at that edge, so a fetch takes one cycle.
- N-wait memory: `stall` is high for N cycles and the capture occurs on the edge where `memReady`=1.
- Interrupt latency from `intReq` rising to `intTaken`: at least 2 cycles (latch, then next fetch edge); unbounded if IE=0.
- `intTaken` is a one-cycle pulse and is never asserted during reset.

## Test plan
- **Reset**: hold `resetN`=0 for 2 cycles with `pcWrite`=1 -> PC=128, `memAddr`=128, `op`=0, `intTaken`=0.
- **Fetch, zero-wait**: fetch with `memRdata`=0x8C820004 and `memReady`=1 -> IR loaded, `op`=0x23, PC=132 (`aluSrcA`=0, `aluSrcB`=01, `pcSource`=00).
- **Fetch, 3-wait**: fetch with `memReady` low for 3 cycles -> `stall`=1 for 3 cycles with PC and IR unchanged; IR loads on the 4th edge; PC=132.
- **Branch**: beq with A=B=5, `isBranch`=1, ALUOut=200 -> `zero`=1, PC=200. Then with A=5, B=6 -> PC unchanged.
- **Interrupt and eret**: pulse `intReq` during execute, then fetch at PC=0x100 -> EPC=0x100, PC=4088, IR unchanged, `intTaken` one cycle, IE=0. A second `intReq` is ignored. eret (`pcSource`=11, `pcWrite`=1) -> PC=0x100, IE=1; the pending second request is then taken at the next fetch.
- **Register writes**: write 0xDEADBEEF to `$0` -> `$0` reads 0. Jal-style write (`regDst`=10, `memToReg`=10) at PC=132 -> `$31`=132.
